bit_scan_serializer: RTL and testbench

BIT_SCAN_SERIALIZER -- requirements
Module: bit_scan_serializer

---
 rtl/bit_scan_pkg.sv | 9 +
 rtl/trailing_one_detect.sv | 22 ++
 rtl/bit_scan_serializer.sv | 113 +++++++++++
 tb/tb_bit_scan_serializer.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bit_scan_pkg.sv
// Shared types for the bit-scan serializer: the two-state scan FSM encoding.
package bit_scan_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } scan_state_t;

endpackage

// File: rtl/trailing_one_detect.sv
// Trailing-one detector: reports the position of the lowest set bit of a word.
module trailing_one_detect
   import bit_scan_pkg::*;
#(
   parameter int DATA_WD = 8,
   parameter int IND_WD  = $clog2(DATA_WD)
) (
   input  logic [DATA_WD-1:0] data,
   output logic [IND_WD-1:0]  index,
   output logic               found
);

   // Walk from the top down so the lowest set bit is the last one written.
   always_comb begin
      index = {IND_WD{1'b0}};
      for (int i = DATA_WD - 1; i >= 0; i--) begin
         index = data[i] ? IND_WD'(i) : index;
      end
      found = |data;
   end

endmodule

// File: rtl/bit_scan_serializer.sv
// Accepts a word and emits, one beat per handshake, the index of each set bit
// in LSB-first or MSB-first order; an all-zero word yields a single "none" beat.
module bit_scan_serializer
   import bit_scan_pkg::*;
#(
   parameter int DATA_WD = 8,
   parameter int IND_WD  = $clog2(DATA_WD)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [DATA_WD-1:0] i_data,
   input  logic               i_msb_first,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [IND_WD-1:0]  o_index,
   output logic               o_last,
   output logic               o_none
);

   localparam logic [IND_WD-1:0]  MAX_IDX  = IND_WD'(DATA_WD - 1);
   localparam logic [DATA_WD-1:0] ONE_MASK = {{(DATA_WD-1){1'b0}}, 1'b1};
   localparam logic [DATA_WD-1:0] ZERO_MASK = {DATA_WD{1'b0}};

   scan_state_t        state_r;
   logic [DATA_WD-1:0] mask_r;
   logic               msb_first_r;
   logic               none_r;

   logic [DATA_WD-1:0] rev_mask_s;
   logic [DATA_WD-1:0] det_in_s;
   logic [IND_WD-1:0]  det_idx_s;
   logic               det_found_s;
   logic [IND_WD-1:0]  scan_idx_s;
   logic [DATA_WD-1:0] clr_s;
   logic               single_s;
   logic               last_s;
   logic               xfer_s;

   // MSB-first reuses the trailing-one detector on the mirrored mask.
   for (genvar g = 0; g < DATA_WD; g++) begin : g_rev
      assign rev_mask_s[g] = mask_r[DATA_WD-1-g];
   end

   assign det_in_s = msb_first_r ? rev_mask_s : mask_r;

   trailing_one_detect #(
      .DATA_WD (DATA_WD),
      .IND_WD  (IND_WD)
   ) u_tod (
      .data  (det_in_s),
      .index (det_idx_s),
      .found (det_found_s)
   );

   assign scan_idx_s = msb_first_r ? (MAX_IDX - det_idx_s) : det_idx_s;
   assign clr_s      = ONE_MASK << scan_idx_s;
   assign single_s   = det_found_s && ((mask_r & (mask_r - ONE_MASK)) == ZERO_MASK);
   assign last_s     = (state_r == EMIT) && (none_r || single_s);
   assign xfer_s     = (state_r == EMIT) && i_ready;

   // Beat outputs are decoded purely from registered state.
   always_comb begin
      o_ready = (state_r == IDLE);
      o_valid = (state_r == EMIT);
      o_last  = last_s;
      o_none  = (state_r == EMIT) && none_r;
      if ((state_r == EMIT) && det_found_s) begin
         o_index = scan_idx_s;
      end else begin
         o_index = {IND_WD{1'b0}};
      end
   end

   // Scan FSM: capture the word on accept, retire one set bit per transfer.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= IDLE;
         mask_r      <= ZERO_MASK;
         msb_first_r <= 1'b0;
         none_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (i_valid) begin
                  mask_r      <= i_data;
                  msb_first_r <= i_msb_first;
                  none_r      <= (i_data == ZERO_MASK);
                  state_r     <= EMIT;
               end
            end
            EMIT: begin
               if (xfer_s) begin
                  if (last_s) begin
                     state_r <= IDLE;
                     mask_r  <= ZERO_MASK;
                     none_r  <= 1'b0;
                  end else begin
                     mask_r  <= mask_r & ~clr_s;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               mask_r  <= ZERO_MASK;
               none_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Scoreboard bench for bit_scan_serializer (DATA_WD=8) with directed vectors.
module tb_bit_scan_serializer;

   typedef struct packed {
      logic [2:0] idx;
      logic       last;
      logic       none;
   } beat_t;

   logic       clk = 1'b0;
   logic       i_rst;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_data;
   logic       i_msb_first;
   logic       o_valid;
   logic       i_ready;
   logic [2:0] o_index;
   logic       o_last;
   logic       o_none;

   beat_t exp_q[$];
   beat_t exp_b;
   int    chk_cnt = 0;
   int    pass_cnt = 0;
   logic  mon_en = 1'b0;

   bit_scan_serializer #(.DATA_WD(8)) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .i_msb_first (i_msb_first),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_index     (o_index),
      .o_last      (o_last),
      .o_none      (o_none)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic push(input int idx, input logic last, input logic none);
      beat_t b;
      b.idx  = 3'(idx);
      b.last = last;
      b.none = none;
      exp_q.push_back(b);
   endtask

   task automatic send_word(input logic [7:0] d, input logic m);
      int n = 0;
      while (!o_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      i_data = d; i_msb_first = m; i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0; i_data = ~d; i_msb_first = ~m;
   endtask

   // Counts negedges until o_ready returns; expn < 0 means only require it returns.
   task automatic wait_idle(input int expn);
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (!o_ready && n < 100);
      if (expn >= 0) chk("cycles_to_idle", n, expn);
      else chk("idle_reached", int'(o_ready), 1);
   endtask

   // Monitor: pops and compares every transferred beat; checks idle flags.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_valid && i_ready && !i_rst) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", int'({o_index, o_last, o_none}), -1);
            end else begin
               exp_b = exp_q.pop_front();
               chk("beat", int'({o_index, o_last, o_none}), int'(exp_b));
            end
         end
         if (!o_valid) chk("idle_flags", int'({o_last, o_none}), 0);
      end
   end

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_msb_first = 1'b0; i_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_index", int'(o_index), 0);
      chk("rst_last_none", int'({o_last, o_none}), 0);
      mon_en = 1'b1;

      push(2, 1'b0, 1'b0); push(5, 1'b0, 1'b0); push(7, 1'b1, 1'b0);
      send_word(8'hA4, 1'b0);
      wait_idle(4);

      push(7, 1'b0, 1'b0); push(5, 1'b0, 1'b0); push(2, 1'b1, 1'b0);
      send_word(8'hA4, 1'b1);
      wait_idle(4);

      for (int k = 7; k >= 0; k--) push(k, (k == 0), 1'b0);
      send_word(8'hFF, 1'b1);
      wait_idle(9);

      push(0, 1'b1, 1'b1);
      send_word(8'h00, 1'b1);
      wait_idle(2);

      i_ready = 1'b0;
      push(0, 1'b0, 1'b0); push(7, 1'b1, 1'b0);
      send_word(8'h81, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_valid", int'(o_valid), 1);
         chk("bp_index", int'(o_index), 0);
      end
      @(posedge clk); #1 i_ready = 1'b1;
      wait_idle(-1);

      push(0, 1'b0, 1'b0);
      send_word(8'h0F, 1'b0);
      @(posedge clk); #1 i_rst = 1'b1;
      @(posedge clk); #1 i_rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", int'(o_valid), 0);
      chk("midrst_ready", int'(o_ready), 1);
      repeat (6) @(negedge clk);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
